// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder plus a carry flop processes the operands
// LSB first, producing a WIDTH-bit registered sum and carry-out per request.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the low WIDTH-1 result bits; the final bit comes straight from the adder.
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_c;

    assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = (res_q >> 1) | ((WIDTH-1)'(fa_s) << (WIDTH-2));
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    sum_d   = {fa_s, res_q};
                    cout_d  = fa_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-012 The datapath SHALL be one 1-bit full adder (sum = x^y^c, carry = x&y | c&(x^y)) plus a carry flip-flop; no WIDTH-bit parallel adder.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 at an edge -> load a, b into shift registers, cin into carry flop, bit counter to 0, go to SHIFT; start=0 -> stay in IDLE.
REQ-015 SHIFT: each edge consumes bit 0 of both operand registers, shifts both right by one, shifts the full-adder sum bit into the MSB of the internal result register, updates the carry flop, and increments the counter.
REQ-016 SHIFT -> DONE at the edge that processes bit WIDTH-1 (counter = WIDTH-1); on that edge sum is loaded from the completed result and cout from the final carry.
REQ-017 DONE lasts one cycle: done=1, busy=0; next edge returns to IDLE, or, if start=1, loads new operands and goes directly to SHIFT.
REQ-018 busy SHALL be 1 exactly while the state is SHIFT.
REQ-019 Latency: start accepted at edge 0 -> done=1 during the cycle after edge WIDTH; result available WIDTH+1 cycles after start is sampled.
REQ-020 start while in SHIFT SHALL be ignored; the operation in flight SHALL be unaffected, and a, b, cin changes during SHIFT SHALL not affect the result.
REQ-021 sum and cout SHALL hold their last completed value until the next completion or reset; they never show partial results.
REQ-022 Overflow SHALL wrap: bits above WIDTH appear only on cout.
REQ-023 Back-to-back operation (start held high) SHALL yield one result every WIDTH+1 cycles with no lost or duplicated done pulse.

Reset
REQ-024 While rst=1, independent of clk: state IDLE, busy=0, done=0, sum=0, cout=0, carry flop, counter and shift registers 0.
REQ-025 rst asserted during SHIFT or DONE SHALL abort the operation; no done pulse follows, and sum and cout read 0.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x00, b=0x00, cin=0, start pulse -> busy high 8 cycles, done pulse, sum=0x00, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
REQ-029 a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 Start 0x0F+0x01, then start pulse with a=0xF0, b=0xF0 in SHIFT cycle 3 -> ignored; sum=0x10, cout=0; single done pulse.
REQ-031 rst asserted in SHIFT cycle 4 of 0x80+0x80 -> busy, done, sum, cout immediately 0; no done after rst release; next start 0x01+0x02 -> sum=0x03.
REQ-032 start held high for three operations (0x01+0x01, 0x7F+0x01, 0xFF+0x00 cin=1) -> done pulses 9 cycles apart; sums 0x02, 0x80, 0x00 with cout 0, 0, 1.
